alu_seq: RTL and testbench

Sequential integer ALU for the RV32I execute stage, directly downstream of the ALU control unit. It consumes the unit's 4-bit operation code plus two operands and returns a registered result with a start/done handshake. Non-shift ops complete in one cycle; shifts run iteratively, one bit per cycle, unless the barrel-shift option is compiled in.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_comb.sv | 52 +++++
 rtl/alu_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the RV32I execute-stage ALU and the ALU
// control unit that feeds it.
//   - ALU_DATAWIDTH : default operand/result width
//   - ALU_OP_*      : 4-bit operation codes driven by the ALU control unit
//   - alu_state_e   : state encoding of the iterative shifter FSM
//   - alu_is_shift  : true for the three shift op codes
package alu_pkg;

  localparam int unsigned ALU_DATAWIDTH = 32;

  localparam logic [3:0] ALU_OP_ADD   = 4'h0;
  localparam logic [3:0] ALU_OP_SUB   = 4'h1;
  localparam logic [3:0] ALU_OP_SLL   = 4'h2;
  localparam logic [3:0] ALU_OP_SLT   = 4'h3;
  localparam logic [3:0] ALU_OP_SLTU  = 4'h4;
  localparam logic [3:0] ALU_OP_XOR   = 4'h5;
  localparam logic [3:0] ALU_OP_SRL   = 4'h6;
  localparam logic [3:0] ALU_OP_SRA   = 4'h7;
  localparam logic [3:0] ALU_OP_OR    = 4'h8;
  localparam logic [3:0] ALU_OP_AND   = 4'h9;
  localparam logic [3:0] ALU_OP_BUFFB = 4'hA;
  localparam logic [3:0] ALU_OP_BUFFA = 4'hB;

  typedef enum logic [0:0] {
    ALU_ST_IDLE  = 1'b0,
    ALU_ST_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic alu_is_shift(input logic [3:0] op);
    logic is_shift;
    case (op)
      ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA: is_shift = 1'b1;
      default:                            is_shift = 1'b0;
    endcase
    return is_shift;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational datapath for every single-cycle ALU operation.
// Build option ALUS_BARREL_SHIFT_EN: when defined, SLL/SRL/SRA are computed
// here by a barrel shifter; otherwise shift ops return A unchanged (the
// sequencer only uses this path for a shift amount of zero).
// Ports:
//   op_i     [3:0]        operation code (alu_pkg::ALU_OP_*)
//   a_i      [DATAWIDTH]  operand A
//   b_i      [DATAWIDTH]  operand B (low $clog2(DATAWIDTH) bits = shamt)
//   result_o [DATAWIDTH]  result; codes C..F give zero
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned DATAWIDTH = ALU_DATAWIDTH
) (
  input  logic [3:0]           op_i,
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  output logic [DATAWIDTH-1:0] result_o
);

`ifdef ALUS_BARREL_SHIFT_EN
  localparam int unsigned SHW = $clog2(DATAWIDTH);
  logic [SHW-1:0] shamt_s;
  assign shamt_s = b_i[SHW-1:0];
`endif

  // Operation decode and result select.
  always_comb begin
    result_o = {DATAWIDTH{1'b0}};
    case (op_i)
      ALU_OP_ADD:   result_o = a_i + b_i;
      ALU_OP_SUB:   result_o = a_i - b_i;
      ALU_OP_SLT:   result_o = {{(DATAWIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_OP_SLTU:  result_o = {{(DATAWIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_OP_XOR:   result_o = a_i ^ b_i;
      ALU_OP_OR:    result_o = a_i | b_i;
      ALU_OP_AND:   result_o = a_i & b_i;
      ALU_OP_BUFFB: result_o = b_i;
      ALU_OP_BUFFA: result_o = a_i;
`ifdef ALUS_BARREL_SHIFT_EN
      ALU_OP_SLL:   result_o = a_i << shamt_s;
      ALU_OP_SRL:   result_o = a_i >> shamt_s;
      ALU_OP_SRA:   result_o = $signed(a_i) >>> shamt_s;
`else
      // Reached only with shamt == 0, where every shift is the identity.
      ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA: result_o = a_i;
`endif
      default:      result_o = {DATAWIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential RV32I ALU with start/done handshake.
// Non-shift ops (and shifts by zero) complete on the Start-sampling edge.
// Shifts by k>0 step one bit per clock in SHIFT state and complete k edges
// later. Build option ALUS_BARREL_SHIFT_EN removes the SHIFT state and
// counter: every op completes in one cycle and Ready is always high.
// Ports:
//   ALUS_CLOCK_50          clock, rising edge
//   ALUS_RESET_InLow       asynchronous active-low reset
//   ALUS_AluControl_InBUS  4-bit op code
//   ALUS_DataA_InBUS       operand A
//   ALUS_DataB_InBUS       operand B / shift amount
//   ALUS_Start_In          request, sampled while Ready is high
//   ALUS_Kill_In           flush, aborts any operation in flight
//   ALUS_Ready_Out         high when a new request can be accepted
//   ALUS_Done_Out          one-cycle pulse, result valid
//   ALUS_Result_OutBUS     registered result, held until next completion
//   ALUS_Zero_Out          registered (Result == 0)
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATAWIDTH = ALU_DATAWIDTH
) (
  input  logic                 ALUS_CLOCK_50,
  input  logic                 ALUS_RESET_InLow,
  input  logic [3:0]           ALUS_AluControl_InBUS,
  input  logic [DATAWIDTH-1:0] ALUS_DataA_InBUS,
  input  logic [DATAWIDTH-1:0] ALUS_DataB_InBUS,
  input  logic                 ALUS_Start_In,
  input  logic                 ALUS_Kill_In,
  output logic                 ALUS_Ready_Out,
  output logic                 ALUS_Done_Out,
  output logic [DATAWIDTH-1:0] ALUS_Result_OutBUS,
  output logic                 ALUS_Zero_Out
);

  logic [DATAWIDTH-1:0] comb_result_s;
  logic [DATAWIDTH-1:0] result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 done_q, done_d;
  logic                 ready_s;
  logic                 accept_s;

  alu_comb #(
    .DATAWIDTH (DATAWIDTH)
  ) u_comb (
    .op_i     (ALUS_AluControl_InBUS),
    .a_i      (ALUS_DataA_InBUS),
    .b_i      (ALUS_DataB_InBUS),
    .result_o (comb_result_s)
  );

  // Kill always wins over a new request.
  assign accept_s = ALUS_Start_In & ~ALUS_Kill_In & ready_s;

`ifdef ALUS_BARREL_SHIFT_EN

  // Single-cycle build: every accepted request completes on its sampling edge.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (accept_s) begin
      result_d = comb_result_s;
      zero_d   = (comb_result_s == {DATAWIDTH{1'b0}});
      done_d   = 1'b1;
    end else begin
      done_d   = 1'b0;
    end
  end

  assign ready_s = 1'b1;

`else

  localparam int unsigned SHW = $clog2(DATAWIDTH);

  alu_state_e           state_q, state_d;
  logic [SHW-1:0]       count_q, count_d;
  logic [SHW-1:0]       shamt_s;
  logic [DATAWIDTH-1:0] acc_q, acc_d;
  logic [DATAWIDTH-1:0] shifted_s;
  logic [3:0]           op_q, op_d;
  logic                 start_shift_s;
  logic                 last_step_s;

  assign shamt_s       = ALUS_DataB_InBUS[SHW-1:0];
  assign start_shift_s = accept_s & alu_is_shift(ALUS_AluControl_InBUS) &
                         (shamt_s != {SHW{1'b0}});
  // Completing edge: count goes 1 -> 0 and no flush pending.
  assign last_step_s   = (state_q == ALU_ST_SHIFT) & ~ALUS_Kill_In &
                         (count_q == SHW'(1));

  // FSM state register.
  always_ff @(posedge ALUS_CLOCK_50 or negedge ALUS_RESET_InLow) begin
    if (!ALUS_RESET_InLow) begin
      state_q <= ALU_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALU_ST_IDLE: begin
        if (start_shift_s) begin
          state_d = ALU_ST_SHIFT;
        end else begin
          state_d = ALU_ST_IDLE;
        end
      end
      ALU_ST_SHIFT: begin
        if (ALUS_Kill_In || last_step_s) begin
          state_d = ALU_ST_IDLE;
        end else begin
          state_d = ALU_ST_SHIFT;
        end
      end
      default: state_d = ALU_ST_IDLE;
    endcase
  end

  // FSM output logic.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ALU_ST_IDLE:  ready_s = 1'b1;
      ALU_ST_SHIFT: ready_s = 1'b0;
      default:      ready_s = 1'b0;
    endcase
  end

  // One-bit step of the shift accumulator, using the op latched at Start.
  always_comb begin
    shifted_s = acc_q;
    case (op_q)
      ALU_OP_SLL: shifted_s = {acc_q[DATAWIDTH-2:0], 1'b0};
      ALU_OP_SRL: shifted_s = {1'b0, acc_q[DATAWIDTH-1:1]};
      ALU_OP_SRA: shifted_s = {acc_q[DATAWIDTH-1], acc_q[DATAWIDTH-1:1]};
      default:    shifted_s = acc_q;
    endcase
  end

  // Datapath next-state: accumulator, counter, latched op and outputs.
  always_comb begin
    acc_d    = acc_q;
    count_d  = count_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      ALU_ST_IDLE: begin
        if (start_shift_s) begin
          acc_d   = ALUS_DataA_InBUS;
          count_d = shamt_s;
          op_d    = ALUS_AluControl_InBUS;
        end else if (accept_s) begin
          result_d = comb_result_s;
          zero_d   = (comb_result_s == {DATAWIDTH{1'b0}});
          done_d   = 1'b1;
        end else begin
          done_d   = 1'b0;
        end
      end
      ALU_ST_SHIFT: begin
        if (ALUS_Kill_In) begin
          count_d = {SHW{1'b0}};
        end else begin
          acc_d   = shifted_s;
          count_d = count_q - SHW'(1);
          if (last_step_s) begin
            result_d = shifted_s;
            zero_d   = (shifted_s == {DATAWIDTH{1'b0}});
            done_d   = 1'b1;
          end else begin
            done_d   = 1'b0;
          end
        end
      end
      default: begin
        count_d = {SHW{1'b0}};
      end
    endcase
  end

  // Shift accumulator, counter and latched op code.
  always_ff @(posedge ALUS_CLOCK_50 or negedge ALUS_RESET_InLow) begin
    if (!ALUS_RESET_InLow) begin
      acc_q   <= {DATAWIDTH{1'b0}};
      count_q <= {SHW{1'b0}};
      op_q    <= 4'h0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

`endif

  // Output registers; Zero always tracks the registered Result.
  always_ff @(posedge ALUS_CLOCK_50 or negedge ALUS_RESET_InLow) begin
    if (!ALUS_RESET_InLow) begin
      result_q <= {DATAWIDTH{1'b0}};
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign ALUS_Ready_Out     = ready_s;
  assign ALUS_Done_Out      = done_q;
  assign ALUS_Result_OutBUS = result_q;
  assign ALUS_Zero_Out      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq with a scoreboard of
// expected results. Expected latency is counted in clock edges after the
// Start-sampling edge until Done is visible.
module tb_alu_seq;
  import alu_pkg::*;

`ifdef ALUS_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  op_in = 4'h0;
  logic [31:0] a_in = 32'h0;
  logic [31:0] b_in = 32'h0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_seq #(.DATAWIDTH(32)) dut (
    .ALUS_CLOCK_50         (clk),
    .ALUS_RESET_InLow      (rst_n),
    .ALUS_AluControl_InBUS (op_in),
    .ALUS_DataA_InBUS      (a_in),
    .ALUS_DataB_InBUS      (b_in),
    .ALUS_Start_In         (start),
    .ALUS_Kill_In          (kill),
    .ALUS_Ready_Out        (ready),
    .ALUS_Done_Out         (done),
    .ALUS_Result_OutBUS    (result),
    .ALUS_Zero_Out         (zero)
  );

  function automatic int shift_lat(input int k);
    return BARREL ? 0 : k;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one Start cycle without scoreboard entry.
  task automatic pulse(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op_in = op; a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat);
    sb_q.push_back('{res: exp_res, lat: exp_lat});
    pulse(op, a, b);
  endtask

  // Wait (bounded) for Done, then pop and compare against the scoreboard.
  task automatic collect(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      check({tag, "_ready_busy"}, {31'h0, ready}, 32'h0);
      tick();
      n++;
    end
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    total++;
    assert (sb_q.size() > 0) else begin
      bad++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_latency"}, n, e.lat);
      check({tag, "_result"}, result, e.res);
      check({tag, "_zero"}, {31'h0, zero}, {31'h0, (e.res == 32'h0)});
      check({tag, "_ready_done"}, {31'h0, ready}, 32'h1);
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_result", result, 32'h0);
    check("rst_zero", {31'h0, zero}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single-cycle ops
    issue(ALU_OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    collect("add_wrap");
    tick();
    check("add_single_pulse", {31'h0, done}, 32'h0);
    issue(ALU_OP_SUB, 32'h5, 32'h7, 32'hFFFF_FFFE, 0);          collect("sub");
    issue(ALU_OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0);          collect("slt");
    issue(ALU_OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);         collect("sltu");
    issue(ALU_OP_BUFFA, 32'h1234_5000, 32'hDEAD, 32'h1234_5000, 0); collect("buffa");
    issue(ALU_OP_BUFFB, 32'h1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0); collect("buffb");
    issue(ALU_OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 0); collect("xor");
    issue(ALU_OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 0);  collect("or");
    issue(ALU_OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0); collect("and");
    issue(4'hD, 32'h1234, 32'h5678, 32'h0, 0);                  collect("code_d");

    // Shifts
    issue(ALU_OP_SRA, 32'h8000_0000, 32'h4, 32'hF800_0000, shift_lat(4)); collect("sra4");
    tick();
    check("sra4_single_pulse", {31'h0, done}, 32'h0);
    issue(ALU_OP_SLL, 32'h0000_ABCD, 32'h20, 32'h0000_ABCD, 0); collect("sll_shamt0");
    issue(ALU_OP_SRL, 32'hF0, 32'h4, 32'hF, shift_lat(4));      collect("srl4");
    issue(ALU_OP_SLL, 32'h1, 32'd31, 32'h8000_0000, shift_lat(31)); collect("sll31");
    issue(ALU_OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, shift_lat(31)); collect("sra31");
    issue(ALU_OP_SLL, 32'h3, 32'h1, 32'h6, shift_lat(1));       collect("sll1");
    // Start in the Done cycle is accepted
    issue(ALU_OP_ADD, 32'd10, 32'd20, 32'd30, 0);               collect("b2b_add");
    tick();
    check("b2b_no_extra_done", {31'h0, done}, 32'h0);

`ifndef ALUS_BARREL_SHIFT_EN
    issue(ALU_OP_BUFFA, 32'h1234_5000, 32'h0, 32'h1234_5000, 0); collect("prior");
    // Kill mid-shift: SRL by 8, flush sampled on the third edge
    pulse(ALU_OP_SRL, 32'hF0, 32'h8);
    tick();
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_no_done", {31'h0, done}, 32'h0);
    check("kill_ready", {31'h0, ready}, 32'h1);
    check("kill_result_held", result, 32'h1234_5000);
    check("kill_zero_held", {31'h0, zero}, 32'h0);
    tick();
    check("kill_no_late_done", {31'h0, done}, 32'h0);
    issue(ALU_OP_ADD, 32'h3, 32'h4, 32'h7, 0);                  collect("after_kill_add");

    // Kill on the completing edge dominates
    pulse(ALU_OP_SLL, 32'h1, 32'h2);
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("killdom_no_done", {31'h0, done}, 32'h0);
    check("killdom_result", result, 32'h7);
    check("killdom_ready", {31'h0, ready}, 32'h1);

    // Kill together with Start in IDLE drops the request
    kill = 1'b1;
    pulse(ALU_OP_SRL, 32'hFF, 32'h2);
    kill = 1'b0;
    check("killstart_no_done", {31'h0, done}, 32'h0);
    check("killstart_ready", {31'h0, ready}, 32'h1);
    tick();
    check("killstart_still_idle", {31'h0, done}, 32'h0);

    // Start while busy is ignored; latched operands unaffected
    sb_q.push_back('{res: 32'h10, lat: 2});
    pulse(ALU_OP_SRL, 32'h80, 32'h3);
    pulse(ALU_OP_ADD, 32'h1, 32'h1);
    collect("busy_srl");
    tick();
    check("busy_no_second_done", {31'h0, done}, 32'h0);
    issue(ALU_OP_ADD, 32'd10, 32'd20, 32'd30, 0);               collect("refill");
`endif

    // Asynchronous reset in the middle of an SRA
    pulse(ALU_OP_SRA, 32'h8000_0000, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", result, 32'h0);
    check("arst_zero", {31'h0, zero}, 32'h1);
    check("arst_ready", {31'h0, ready}, 32'h1);
    check("arst_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_idle_done", {31'h0, done}, 32'h0);
    issue(ALU_OP_ADD, 32'hFF, 32'h1, 32'h100, 0);               collect("post_reset_add");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
